div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
- Iterative 32-bit divider with its own sequencer. Sits beside the EX stage and serves DIV/DIVU.
- Holds the pipeline through the stall controller's stallreq_for_ex input while a division is in progress.
- Presents quotient (LO) and remainder (HI) to EX until EX advances.
- Contains a radix-2 restoring datapath (one quotient bit per cycle) and a 3-state FSM that handles cancellation and pipeline-stall interaction.

Parameters:
- WIDTH, 32, operand/result width (only 32 is verified)
- CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous, active-low reset
- div_start  input  1  EX holds a DIV/DIVU; stays high while EX is stalled
- div_signed  input  1  1 = DIV (two's complement), 0 = DIVU
- opdata1  input  WIDTH  dividend (rs)
- opdata2  input  WIDTH  divisor (rt)
- annul  input  1  flush of EX (exception/redirect); cancels any division
- ex_stall  input  1  stall bus bit for EX (stall[3]); 1 = EX holds its instruction this cycle
- stallreq_for_ex  output  1  request pipeline stall up to EX
- result_valid  output  1  quotient/remainder valid for the instruction in EX
- quotient  output  WIDTH  LO result
- remainder  output  WIDTH  HI result

Behaviour:
- Reset (resetn=0, async):
  - state=IDLE
  - quotient=0, remainder=0, result_valid=0
  - internal dividend/divisor/counter/sign flags = 0
- stallreq_for_ex (combinational) = div_start & ~annul & (state!=DONE). It is therefore asserted in the IDLE cycle that sees div_start.
- IDLE:
  - div_start=1, annul=0, opdata2==0 → DONE with quotient=all-ones, remainder=opdata1 (both registered).
  - div_start=1, annul=0, opdata2!=0:
    - latch |opdata1| and |opdata2| (absolute value only when div_signed, else raw);
    - latch neg_q = signed & (op1[31]^op2[31]) and neg_r = signed & op1[31];
    - clear partial remainder and counter; → BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Each cycle: shift {rem,dvd} left by 1, then trial-subtract divisor from rem. If no borrow, rem=difference and quotient bit=1; else rem is kept and bit=0. Counter increments.
  - After WIDTH iterations → DONE:
    - quotient = neg_q ? -q : q;
    - remainder = neg_r ? -r : r;
    - result_valid=1.
  - Operands are not re-sampled during BUSY. Changes on opdata1/2 are ignored.
- DONE:
  - result_valid=1 and stallreq_for_ex=0; results held stable.
  - If ex_stall=0, EX consumes the result this cycle → IDLE next cycle (result_valid=0, outputs hold their last values).
  - If ex_stall=1 (stall caused by ID or a later stage), remain in DONE. No restart, even though div_start stays high.
- annul in any state → IDLE next edge, result_valid=0, no result write. annul has priority over every transition, including BUSY→DONE on the final iteration.
- Latency for a nonzero divisor:
  - start seen in cycle 0; BUSY cycles 1..WIDTH; result_valid from cycle WIDTH+1 (=33).
  - stallreq_for_ex high for cycles 0..32 (33 cycles).
- Latency for a zero divisor: result_valid in cycle 1; stallreq for 1 cycle.
- Back-to-back divisions: a second DIV reaching EX the cycle after DONE→IDLE starts normally; there is no dead cycle beyond the IDLE sample.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000, remainder=0. This falls out of unsigned-magnitude arithmetic; no special case.
- A reset asserted mid-BUSY aborts immediately. After release the FSM is in IDLE with outputs zero.

Test Plan:
- DIVU 100/7, ex_stall follows stallreq:
  - stallreq high 33 cycles;
  - cycle 33: result_valid=1, quotient=14, remainder=2;
  - IDLE on cycle 34.
- DIV -7/2 (0xFFFFFFF9/0x2) → quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). DIV 0x80000000/0xFFFFFFFF → quotient=0x80000000, remainder=0.
- DIVU 5/0 → result_valid at cycle 1, quotient=0xFFFFFFFF, remainder=5, stallreq high only in cycle 0.
- annul pulsed at BUSY iteration 10 → IDLE next cycle, result_valid never asserted, stallreq drops. A fresh DIVU 9/3 afterwards gives quotient=3, remainder=0.
- Reach DONE with ex_stall held 1 for 4 extra cycles (div_start held) → state stays DONE, outputs constant, no restart. Releasing ex_stall → IDLE next cycle.
- Drive resetn low in the middle of BUSY → outputs 0 asynchronously. Release, then DIVU 0xFFFFFFFF/0x10 → quotient=0x0FFFFFFF, remainder=0xF.

Source files
------------

// File: rtl/div_if.sv
// EX-side handshake bundle for the iterative divider: operands and control in,
// stall request and registered LO/HI results out.
interface div_if #(
  parameter int WIDTH = 32
);
  logic             div_start;
  logic             div_signed;
  logic [WIDTH-1:0] opdata1;
  logic [WIDTH-1:0] opdata2;
  logic             annul;
  logic             ex_stall;
  logic             stallreq_for_ex;
  logic             result_valid;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output div_start, div_signed, opdata1, opdata2, annul, ex_stall,
    input  stallreq_for_ex, result_valid, quotient, remainder
  );

  modport slave (
    input  div_start, div_signed, opdata1, opdata2, annul, ex_stall,
    output stallreq_for_ex, result_valid, quotient, remainder
  );
endinterface

// File: rtl/div_ctrl.sv
// Radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle, with an
// IDLE/BUSY/DONE sequencer that stalls EX and tracks flushes and EX stalls.
module div_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic  clk,
  input  logic  resetn,
  div_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] rem;
  logic [CNT_W-1:0] cnt;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] quotient_hold;
  logic [WIDTH-1:0] remainder_hold;
  logic             valid_hold;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] dvd_next;
  logic             last_iter;
  logic             start_ok;
  logic             divisor_zero;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
    if (en) begin
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  function automatic logic [WIDTH-1:0] abs_if(input logic [WIDTH-1:0] v, input logic sgn);
    return neg_if(v, sgn & v[WIDTH-1]);
  endfunction

  assign start_ok     = bus.div_start & ~bus.annul;
  assign divisor_zero = (bus.opdata2 == {WIDTH{1'b0}});

  // One restoring step: the carry out of rem joins the trial value so the compare never overflows.
  always_comb begin
    trial     = {rem, dvd[WIDTH-1]};
    diff      = trial - {1'b0, dsr};
    no_borrow = (trial >= {1'b0, dsr});
    if (no_borrow) begin
      rem_next = diff[WIDTH-1:0];
    end else begin
      rem_next = trial[WIDTH-1:0];
    end
    dvd_next  = {dvd[WIDTH-2:0], no_borrow};
    last_iter = (cnt == CNT_W'(WIDTH - 1));
  end

  // Next-state logic; annul overrides every other transition.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_ok) begin
          if (divisor_zero) begin
            next_state = DONE;
          end else begin
            next_state = BUSY;
          end
        end else begin
          next_state = IDLE;
        end
      end
      BUSY: begin
        if (bus.annul) begin
          next_state = IDLE;
        end else if (last_iter) begin
          next_state = DONE;
        end else begin
          next_state = BUSY;
        end
      end
      DONE: begin
        if (bus.annul || !bus.ex_stall) begin
          next_state = IDLE;
        end else begin
          next_state = DONE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Operand capture, iteration datapath and registered results.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dvd            <= {WIDTH{1'b0}};
      dsr            <= {WIDTH{1'b0}};
      rem            <= {WIDTH{1'b0}};
      cnt            <= {CNT_W{1'b0}};
      neg_q          <= 1'b0;
      neg_r          <= 1'b0;
      quotient_hold  <= {WIDTH{1'b0}};
      remainder_hold <= {WIDTH{1'b0}};
      valid_hold     <= 1'b0;
    end else begin
      valid_hold <= (next_state == DONE);
      case (state)
        IDLE: begin
          if (start_ok) begin
            if (divisor_zero) begin
              quotient_hold  <= {WIDTH{1'b1}};
              remainder_hold <= bus.opdata1;
            end else begin
              dvd   <= abs_if(bus.opdata1, bus.div_signed);
              dsr   <= abs_if(bus.opdata2, bus.div_signed);
              neg_q <= bus.div_signed & (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
              neg_r <= bus.div_signed & bus.opdata1[WIDTH-1];
              rem   <= {WIDTH{1'b0}};
              cnt   <= {CNT_W{1'b0}};
            end
          end
        end
        BUSY: begin
          if (!bus.annul) begin
            rem <= rem_next;
            dvd <= dvd_next;
            cnt <= cnt + CNT_W'(1);
            if (last_iter) begin
              quotient_hold  <= neg_if(dvd_next, neg_q);
              remainder_hold <= neg_if(rem_next, neg_r);
            end
          end
        end
        DONE: begin
          dvd <= dvd;
        end
        default: begin
          cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.stallreq_for_ex = start_ok & (state != DONE);
  assign bus.result_valid    = valid_hold;
  assign bus.quotient        = quotient_hold;
  assign bus.remainder       = remainder_hold;

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: directed divisions push expected LO/HI results,
// a negedge monitor pops and compares on each rising result_valid.
module tb_div_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  div_if #(.WIDTH(W)) bus ();

  div_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_pushed = 0;
  int n_seen   = 0;
  logic [2*W-1:0] exp_q[$];
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic monitor_step();
    logic [2*W-1:0] e;
    if (resetn === 1'b1 && bus.result_valid === 1'b1 && prev_valid === 1'b0) begin
      n_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(bus.result_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("quotient", bus.quotient, e[2*W-1:W]);
        chk("remainder", bus.remainder, e[W-1:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    monitor_step();
    prev_valid <= bus.result_valid;
  end

  // One division with ex_stall following stallreq, optional extra EX-stall cycles in DONE.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input int lat, input int hold);
    int cyc;
    int stalls;
    exp_q.push_back({eq, er});
    n_pushed++;
    bus.opdata1    = a;
    bus.opdata2    = b;
    bus.div_signed = sgn;
    bus.div_start  = 1'b1;
    #1;
    bus.ex_stall = bus.stallreq_for_ex;
    stalls = (bus.stallreq_for_ex === 1'b1) ? 1 : 0;
    cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      #1;
      if (bus.result_valid === 1'b1) break;
      if (bus.stallreq_for_ex === 1'b1) stalls++;
      bus.ex_stall = bus.stallreq_for_ex;
      if (cyc == 5) begin
        bus.opdata1 = ~a;
        bus.opdata2 = b ^ 32'h0000_0005;
      end
    end
    chk("latency", 32'(cyc), 32'(lat));
    chk("stall_cycles", 32'(stalls), 32'(lat));
    chk("stall_in_done", 32'(bus.stallreq_for_ex), 32'd0);
    for (int i = 0; i < hold; i++) begin
      bus.ex_stall = 1'b1;
      @(negedge clk);
      #1;
      chk("hold_valid", 32'(bus.result_valid), 32'd1);
      chk("hold_quotient", bus.quotient, eq);
      chk("hold_remainder", bus.remainder, er);
      chk("hold_stall", 32'(bus.stallreq_for_ex), 32'd0);
    end
    bus.ex_stall  = 1'b0;
    bus.div_start = 1'b0;
    @(negedge clk);
    #1;
    chk("valid_after_consume", 32'(bus.result_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    resetn         = 1'b0;
    bus.div_start  = 1'b0;
    bus.div_signed = 1'b0;
    bus.opdata1    = 32'd0;
    bus.opdata2    = 32'd0;
    bus.annul      = 1'b0;
    bus.ex_stall   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_quotient", bus.quotient, 32'd0);
    chk("reset_remainder", bus.remainder, 32'd0);
    chk("reset_valid", 32'(bus.result_valid), 32'd0);
    chk("reset_stall", 32'(bus.stallreq_for_ex), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    #1;

    run_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, 0);
    run_div(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0000_0000, 33, 0);
    run_div(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1, 0);

    // Flush in the middle of BUSY: no result may appear.
    bus.opdata1    = 32'd1000;
    bus.opdata2    = 32'd3;
    bus.div_signed = 1'b0;
    bus.div_start  = 1'b1;
    bus.ex_stall   = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    bus.annul = 1'b1;
    #1;
    chk("stall_on_annul", 32'(bus.stallreq_for_ex), 32'd0);
    @(negedge clk);
    #1;
    bus.annul     = 1'b0;
    bus.div_start = 1'b0;
    bus.ex_stall  = 1'b0;
    chk("valid_after_annul", 32'(bus.result_valid), 32'd0);
    repeat (40) @(negedge clk);
    #1;
    chk("valid_long_after_annul", 32'(bus.result_valid), 32'd0);
    run_div(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 33, 0);

    run_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, 4);

    // Asynchronous reset in the middle of BUSY.
    bus.opdata1   = 32'd1000;
    bus.opdata2   = 32'd3;
    bus.div_start = 1'b1;
    bus.ex_stall  = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("async_reset_quotient", bus.quotient, 32'd0);
    chk("async_reset_remainder", bus.remainder, 32'd0);
    chk("async_reset_valid", 32'(bus.result_valid), 32'd0);
    bus.div_start = 1'b0;
    bus.ex_stall  = 1'b0;
    @(negedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    #1;
    chk("post_reset_valid", 32'(bus.result_valid), 32'd0);
    chk("post_reset_quotient", bus.quotient, 32'd0);
    run_div(32'hFFFF_FFFF, 32'h0000_0010, 1'b0, 32'h0FFF_FFFF, 32'h0000_000F, 33, 0);

    repeat (3) @(negedge clk);
    #1;
    chk("results_seen", 32'(n_seen), 32'(n_pushed));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
